// File: rtl/fp16_add_norm_pkg.sv
// Shared half-precision field definitions for the fp16 adder slice (align and add/normalize stages).
package fp16_add_norm_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int GRS_W   = 3;
  localparam int EXP_MAX = 31;

  // Significand with hidden bit and G/R/S, plus one carry bit for the adder result
  localparam int SML_W = FRAC_W + GRS_W + 1;
  localparam int MAG_W = SML_W + 1;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/fp16_add_norm_if.sv
// Operand/result handshake bundle between the align stage, the add/normalize block and its consumer.
interface fp16_add_norm_if;
  import fp16_add_norm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  fp16_t            in_big;
  logic [SML_W-1:0] in_sml_m;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  fp16_t            out_sum;
  flags_t           out_flags;

  modport master (
    output in_valid, in_big, in_sml_m, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_big, in_sml_m, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );

endinterface

// File: rtl/fp16_add_norm_lzc14.sv
// Combinational 14-bit leading-zero counter; an all-zero input reports 14.
module lzc14 (
  input  logic [13:0] din,
  output logic [3:0]  cnt
);

  // Ascending scan so the most significant set bit is the last one to win
  always_comb begin
    cnt = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (din[i]) begin
        cnt = 4'(13 - i);
      end
    end
  end

endmodule

// File: rtl/fp16_add_norm.sv
// Two-stage elastic fp16 add/normalize pipeline: ADD forms the signed-magnitude sum,
// NORM normalizes, rounds to nearest-even and applies overflow/underflow/zero handling.
module fp16_add_norm
  import fp16_add_norm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp16_add_norm_if.slave bus
);

  localparam logic signed [6:0] EXP_TOP = 7'(EXP_MAX);

  logic             addv;
  logic [MAG_W-1:0] add_mag;
  logic             add_sign;
  fp16_t            add_big;

  logic             normv;
  fp16_t            sum_q;
  flags_t           flags_q;

  logic             norm_en;

  logic [MAG_W-1:0] big_m;
  logic [MAG_W-1:0] sml_ext;
  logic [MAG_W:0]   diff;
  logic [MAG_W-1:0] mag_c;
  logic             sign_c;

  logic [3:0]        lz;
  logic [SML_W-1:0]  sig;
  logic signed [6:0] exp_s;
  logic signed [6:0] exp_f;
  logic              rnd;
  logic [FRAC_W:0]   frac_r;
  logic              mag_zero;
  fp16_t             res_sum;
  flags_t            res_flags;

  assign norm_en      = !normv || bus.out_ready;
  assign bus.in_ready = !addv || norm_en;
  assign bus.out_valid = normv;
  assign bus.out_sum   = sum_q;
  assign bus.out_flags = flags_q;

  // A borrow means the smaller operand actually won: negate the magnitude and flip the sign
  always_comb begin
    big_m   = {2'b01, bus.in_big.frac, {GRS_W{1'b0}}};
    sml_ext = {1'b0, bus.in_sml_m};
    diff    = {1'b0, big_m} - {1'b0, sml_ext};
    mag_c   = big_m + sml_ext;
    sign_c  = bus.in_big.sign;
    if (bus.in_sub) begin
      mag_c = diff[MAG_W-1:0];
      if (diff[MAG_W]) begin
        mag_c  = (~diff[MAG_W-1:0]) + MAG_W'(1);
        sign_c = ~bus.in_big.sign;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addv     <= 1'b0;
      add_mag  <= '0;
      add_sign <= 1'b0;
      add_big  <= '0;
    end else if (bus.in_ready) begin
      addv <= bus.in_valid;
      if (bus.in_valid) begin
        add_mag  <= mag_c;
        add_sign <= sign_c;
        add_big  <= bus.in_big;
      end
    end
  end

  lzc14 u_lzc (
    .din (add_mag[SML_W-1:0]),
    .cnt (lz)
  );

  // After the left shift the hidden bit is set unless the whole magnitude was zero
  always_comb begin
    sig   = add_mag[SML_W-1:0] << lz;
    exp_s = $signed({2'b00, add_big.exp}) - $signed({3'b000, lz});
    if (add_mag[MAG_W-1]) begin
      sig   = {add_mag[MAG_W-1:2], |add_mag[1:0]};
      exp_s = $signed({2'b00, add_big.exp}) + 7'sd1;
    end
    mag_zero = !add_mag[MAG_W-1] && !sig[SML_W-1];

    rnd    = sig[2] & (sig[1] | sig[0] | sig[3]);
    frac_r = {1'b0, sig[SML_W-2:GRS_W]} + {{FRAC_W{1'b0}}, rnd};
    exp_f  = exp_s;
    if (frac_r[FRAC_W]) begin
      exp_f = exp_s + 7'sd1;
    end

    res_flags = '0;
    res_sum   = {add_sign, exp_f[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    if (add_big.exp == EXP_W'(EXP_MAX)) begin
      res_sum = add_big;
    end else if (mag_zero) begin
      res_sum              = '0;
      res_flags[FLAG_ZERO] = 1'b1;
    end else if (exp_f >= EXP_TOP) begin
      res_sum             = {add_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      res_flags[FLAG_OVF] = 1'b1;
    end else if (exp_f <= 7'sd0) begin
      res_sum            = {add_sign, {(EXP_W + FRAC_W){1'b0}}};
      res_flags[FLAG_UF] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      normv   <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else if (norm_en) begin
      normv <= addv;
      if (addv) begin
        sum_q   <= res_sum;
        flags_q <= res_flags;
      end
    end
  end

endmodule

// File: doc/fp16_add_norm.md
FP16_ADD_NORM -- requirements
Module: fp16_add_norm

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state rises on posedge.
- rst  in  1  asynchronous, active-high reset.
REQ-002 Input ports SHALL be:
- in_valid  in  1  operand set valid.
- in_ready  out  1  block accepts on in_valid&&in_ready.
- in_big  in  16  larger-magnitude operand {sign, exp[4:0], frac[9:0]} from the align stage.
- in_sml_m  in  14  smaller significand aligned to in_big exponent: [13]=hidden bit, [12:3]=frac, [2:0]=guard/round/sticky.
- in_sub  in  1  effective subtraction (operand signs differ).
REQ-003 Output ports SHALL be:
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts on out_valid&&out_ready.
- out_sum  out  16  IEEE half-precision result.
- out_flags  out  3  {ovf, uf, zero}.

Function
REQ-004 The block SHALL be a two-stage elastic pipeline, ADD then NORM, with a latency of exactly 2 cycles from acceptance to out_valid when there is no stall.
REQ-005 The ADD stage SHALL form a 15-bit magnitude: {1,frac_big,000} plus in_sml_m, or minus in_sml_m when in_sub=1.
- If the subtraction borrows, the stage SHALL two's-complement the magnitude and invert the result sign.
REQ-006 The NORM stage SHALL normalize the magnitude in one of two ways:
- On carry (bit14 set): shift right 1, exp+1, OR the shifted-out bit into sticky.
- Otherwise: shift left by the leading-zero count of bits[13:0] and subtract that count from exp.
REQ-007 Rounding SHALL be round-to-nearest-even on G/R/S.
- A rounding carry out of frac SHALL increment exp and clear frac.
REQ-008 A zero magnitude SHALL produce out_sum=16'h0000 with zero=1, regardless of sign.
REQ-009 A final exp>=31 SHALL produce out_sum={sign,5'h1F,10'h0} with ovf=1.
REQ-010 A final exp<=0 SHALL flush to signed zero {sign,15'h0} with uf=1.
REQ-011 If in_big.exp==31 (Inf/NaN), the block SHALL pass in_big through unchanged with all flags 0.
REQ-012 Each stage register SHALL advance when its downstream slot is empty or being drained.
- in_ready = !addV || (!normV || out_ready).
- No entry SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-013 out_sum and out_flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 Simultaneous accept and drain SHALL sustain a throughput of 1 result per cycle.

Reset
REQ-015 Reset SHALL clear both stage-valid bits, out_valid, out_sum (16'h0000) and out_flags (3'b000), asynchronously.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight entries.
- After release, the first out_valid SHALL occur no earlier than 2 cycles after the first accept.
REQ-017 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-018 A shared fp16 package SHALL hold the following, and the align stage SHALL import the same package:
- Field widths (EXP_W=5, FRAC_W=10, GRS_W=3).
- EXP_MAX=31.
- The flag bit indices.
REQ-019 A combinational sub-module lzc14 SHALL provide the 14-bit leading-zero count (4-bit output, value 14 for all-zero).
- The NORM stage SHALL instantiate lzc14 exactly once.

Verification
REQ-020 Basic add: in_big=16'h3C00, in_sml_m=14'h2000, in_sub=0 -> out_sum=16'h4000, flags=000, out_valid exactly 2 cycles after accept.
REQ-021 Cancellation: in_big=16'h3C00, in_sml_m=14'h2000, in_sub=1 -> out_sum=16'h0000, zero=1.
REQ-022 Overflow: in_big=16'h7BFF, in_sml_m=14'h3FF8, in_sub=0 -> out_sum=16'h7C00, ovf=1.
REQ-023 Ties-to-even: in_big=16'h3C00, in_sml_m=14'h0004 -> out_sum=16'h3C00; in_big=16'h3C01, in_sml_m=14'h0004 -> out_sum=16'h3C02.
REQ-024 Backpressure: push 4 back-to-back operands with out_ready=0 for 6 cycles -> in_ready drops after 2 accepts; after release all 4 results emerge in order, unchanged while stalled.
REQ-025 Reset mid-flight: assert rst with 2 entries in flight -> out_valid=0 immediately, no stale result after release, and the next operand yields a correct result 2 cycles after accept.
